// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit.
// Opcode selects, FSM encoding and the two's complement helper.
package muldiv_pkg;

    localparam logic [2:0] FUNCT3_MUL    = 3'd0;
    localparam logic [2:0] FUNCT3_MULH   = 3'd1;
    localparam logic [2:0] FUNCT3_MULHSU = 3'd2;
    localparam logic [2:0] FUNCT3_MULHU  = 3'd3;
    localparam logic [2:0] FUNCT3_DIV    = 3'd4;
    localparam logic [2:0] FUNCT3_DIVU   = 3'd5;
    localparam logic [2:0] FUNCT3_REM    = 3'd6;
    localparam logic [2:0] FUNCT3_REMU   = 3'd7;

    // Widest value twos_neg handles: a full 2*DATA_WIDTH product up to W=64.
    localparam int NEG_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [NEG_W-1:0] twos_neg(
        input logic [NEG_W-1:0] v
    );
        return ~v + NEG_W'(1);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's complement: signed value to magnitude and back.
// Used on both operands at capture and on the product/quotient/remainder.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    assign res = neg ? WIDTH'(twos_neg(NEG_W'(val))) : val;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide beside the EX-stage ALU.
// One bit per cycle; stalls the front end until the one-cycle result.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int REGISTER_ADDR_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_EX,
    input  logic                           flush_EX,
    input  logic [2:0]                     funct3_EX,
    input  logic [DATA_WIDTH-1:0]          rs1_val_EX,
    input  logic [DATA_WIDTH-1:0]          rs2_val_EX,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX,
    output logic                           stall_muldiv,
    output logic                           done_muldiv,
    output logic [DATA_WIDTH-1:0]          result_muldiv,
    output logic [REGISTER_ADDR_WIDTH-1:0] rd_muldiv
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    state_t                         state;
    logic [CW-1:0]                  cnt;
    logic [2:0]                     op_q;
    logic [W-1:0]                   op_a;
    logic [W-1:0]                   op_b;
    logic [2*W-1:0]                 acc;
    logic [W:0]                     rem;
    logic                           neg_res;
    logic                           neg_rem;
    logic [W-1:0]                   result_q;
    logic [REGISTER_ADDR_WIDTH-1:0] rd_q;

    logic         s1;
    logic         s2;
    logic [W-1:0] mag1;
    logic [W-1:0] mag2;

    assign s1 = rs1_val_EX[W-1] & (funct3_EX == FUNCT3_MULH
              | funct3_EX == FUNCT3_MULHSU
              | funct3_EX == FUNCT3_DIV
              | funct3_EX == FUNCT3_REM);
    assign s2 = rs2_val_EX[W-1] & (funct3_EX == FUNCT3_MULH
              | funct3_EX == FUNCT3_DIV
              | funct3_EX == FUNCT3_REM);

    muldiv_sign_fix #(.WIDTH(W)) u_mag1 (
        .val(rs1_val_EX), .neg(s1), .res(mag1)
    );
    muldiv_sign_fix #(.WIDTH(W)) u_mag2 (
        .val(rs2_val_EX), .neg(s2), .res(mag2)
    );

    logic         div_zero;
    logic         div_ovf;
    logic         special;
    logic [W-1:0] special_res;

    assign div_zero = (rs2_val_EX == '0);
    assign div_ovf  = ~funct3_EX[0] & (rs1_val_EX == MOST_NEG)
                    & (rs2_val_EX == '1);
    assign special  = funct3_EX[2] & (div_zero | div_ovf);
    assign special_res = div_zero
                       ? (funct3_EX[1] ? rs1_val_EX : '1)
                       : (funct3_EX[1] ? '0 : MOST_NEG);

    logic [W:0]     mul_sum;
    logic [2*W-1:0] acc_mul;

    assign mul_sum = {1'b0, acc[2*W-1:W]}
                   + (acc[0] ? {1'b0, op_a} : '0);
    assign acc_mul = {mul_sum, acc[W-1:1]};

    // rem holds the last trial difference; a negative trial is restored
    // at the start of the next step rather than in the step that made it.
    logic [W-1:0] rem_rst;
    logic [W:0]   div_sh;
    logic [W:0]   div_trial;
    logic [W-1:0] quo_nxt;
    logic [W-1:0] rem_fin;

    assign rem_rst   = rem[W] ? rem[W-1:0] + op_b : rem[W-1:0];
    assign div_sh    = {rem_rst, acc[W-1]};
    assign div_trial = div_sh - {1'b0, op_b};
    assign quo_nxt   = {acc[W-2:0], ~div_trial[W]};
    assign rem_fin   = div_trial[W] ? div_trial[W-1:0] + op_b
                                    : div_trial[W-1:0];

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;

    muldiv_sign_fix #(.WIDTH(2*W)) u_prod (
        .val(acc_mul), .neg(neg_res), .res(prod_fix)
    );
    muldiv_sign_fix #(.WIDTH(W)) u_quo (
        .val(quo_nxt), .neg(neg_res), .res(quo_fix)
    );
    muldiv_sign_fix #(.WIDTH(W)) u_rem (
        .val(rem_fin), .neg(neg_rem), .res(rem_fix)
    );

    logic [W-1:0] res_mux;

    always_comb begin
        res_mux = rem_fix;
        unique case (op_q)
            FUNCT3_MUL:    res_mux = prod_fix[W-1:0];
            FUNCT3_MULH,
            FUNCT3_MULHSU,
            FUNCT3_MULHU:  res_mux = prod_fix[2*W-1:W];
            FUNCT3_DIV,
            FUNCT3_DIVU:   res_mux = quo_fix;
            default:       res_mux = rem_fix;
        endcase
    end

    logic last;
    assign last = (cnt == CW'(W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            rem      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
        end else if (flush_EX) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_EX) begin
                        op_q    <= funct3_EX;
                        rd_q    <= rd_EX;
                        op_a    <= mag1;
                        op_b    <= mag2;
                        neg_res <= s1 ^ s2;
                        neg_rem <= s1;
                        rem     <= '0;
                        cnt     <= '0;
                        if (special) begin
                            result_q <= special_res;
                            state    <= ST_DONE;
                        end else if (funct3_EX[2]) begin
                            acc   <= {{W{1'b0}}, mag1};
                            state <= ST_DIV;
                        end else begin
                            acc   <= {{W{1'b0}}, mag2};
                            state <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    acc <= acc_mul;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        result_q <= res_mux;
                        cnt      <= '0;
                        state    <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    acc <= {acc[2*W-1:W], quo_nxt};
                    rem <= div_trial;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        result_q <= res_mux;
                        cnt      <= '0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    result_q <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall_muldiv  = ~rst & ~flush_EX
                         & ((state == ST_IDLE & start_EX)
                          | state == ST_MUL
                          | state == ST_DIV);
    assign done_muldiv   = (state == ST_DONE);
    assign result_muldiv = result_q;
    assign rd_muldiv     = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed cases plus random ops against an
// arithmetic reference of the RV32M rules.
module tb_ex_muldiv;

    localparam int W = 32;
    localparam logic [W-1:0] MNEG = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         flush;
    logic [2:0]   f3;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic [4:0]   rd;
    logic         stall;
    logic         done;
    logic [W-1:0] result;
    logic [4:0]   rd_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_muldiv #(
        .DATA_WIDTH(W),
        .REGISTER_ADDR_WIDTH(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_EX(start),
        .flush_EX(flush),
        .funct3_EX(f3),
        .rs1_val_EX(rs1),
        .rs2_val_EX(rs2),
        .rd_EX(rd),
        .stall_muldiv(stall),
        .done_muldiv(done),
        .result_muldiv(result),
        .rd_muldiv(rd_out)
    );

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic bit is_special(input logic [2:0] f,
                                      input logic [W-1:0] a, b);
        if (!f[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return !f[0] && a == MNEG && b == 32'hFFFF_FFFF;
    endfunction

    // Reference: signed/unsigned arithmetic straight from the ISA rules.
    function automatic logic [W-1:0] model(input logic [2:0] f,
                                           input logic [W-1:0] a, b);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        int                 sa;
        int                 sb;
        sa = a;
        sb = b;
        case (f)
            3'd0: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
            3'd1: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return ps[63:32];
            end
            3'd2: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
                return ps[63:32];
            end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MNEG && sb == -1) return MNEG;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MNEG && sb == -1) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Runs one op from its start cycle; b2b leaves the cycle after DONE
    // to the caller so the next op can start there.
    task automatic do_op(input logic [2:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] r,
                         input logic [W-1:0] exp, input bit hold,
                         input bit b2b);
        int lat;
        int first_bad;
        string nm;
        lat = is_special(f, a, b) ? 1 : W + 1;
        first_bad = -1;
        nm = $sformatf("f3=%0d a=%h b=%h", f, a, b);
        cyc();
        start = 1'b1; flush = 1'b0;
        f3 = f; rs1 = a; rs2 = b; rd = r;
        mid();
        chk({nm, " start_stall_done"}, {stall, done}, 2'b10);
        for (int c = 1; c < lat; c++) begin
            cyc();
            if (!hold) begin
                start = 1'b0;
                rs1 = $urandom;
                rs2 = $urandom;
                f3 = 3'($urandom);
                rd = 5'($urandom);
            end
            mid();
            if ({stall, done} !== 2'b10 && first_bad < 0) first_bad = c;
        end
        if (lat > 1)
            chk({nm, " busy_window_first_bad_cycle"},
                64'(first_bad), 64'(-1));
        cyc();
        if (!hold) start = 1'b0;
        mid();
        chk({nm, " done_stall_done"}, {stall, done}, 2'b01);
        chk({nm, " result"}, result, exp);
        chk({nm, " rd"}, rd_out, r);
        if (!b2b) begin
            cyc();
            start = 1'b0;
            mid();
            chk({nm, " after_done"}, {stall, done, result}, '0);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MNEG;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]   rf;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [4:0]   rr;
        rst = 1'b1; start = 1'b1; flush = 1'b0;
        f3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4; rd = 5'd9;
        mid();
        chk("reset_outputs", {stall, done, result, rd_out}, '0);
        cyc();
        rst = 1'b0; start = 1'b0;

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFEB, 0, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,
              32'hFFFF_FFFE, 0, 0);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0, 0, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF, 0, 0);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 0, 0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 0, 0);
        do_op(3'd5, 32'd100, 32'd7, 5'd6, 32'd14, 0, 0);
        do_op(3'd7, 32'd100, 32'd7, 5'd7, 32'd2, 0, 0);
        do_op(3'd4, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 0, 0);
        do_op(3'd7, 32'd5, 32'd0, 5'd9, 32'd5, 0, 0);
        do_op(3'd4, MNEG, 32'hFFFF_FFFF, 5'd10, MNEG, 0, 0);
        do_op(3'd6, MNEG, 32'hFFFF_FFFF, 5'd12, 32'h0, 0, 0);

        // start held through DONE, then a back-to-back op
        do_op(3'd5, 32'd1000, 32'd9, 5'd13, 32'd111, 1, 1);
        do_op(3'd0, 32'd12, 32'd12, 5'd14, 32'd144, 1, 0);

        // flush in cycle 10 of a DIV, new MUL in cycle 11
        cyc();
        start = 1'b1; f3 = 3'd4; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd15;
        mid();
        for (int c = 1; c < 10; c++) begin
            cyc();
            start = 1'b0;
            mid();
        end
        cyc();
        flush = 1'b1;
        mid();
        chk("flush_cycle_stall_done", {stall, done}, 2'b00);
        do_op(3'd0, 32'd3, 32'd5, 5'd16, 32'd15, 0, 0);

        // async reset at cycle 5 of a MUL
        cyc();
        start = 1'b1; f3 = 3'd0; rs1 = 32'd6; rs2 = 32'd7; rd = 5'd17;
        mid();
        for (int c = 1; c < 5; c++) begin
            cyc();
            start = 1'b0;
            mid();
        end
        cyc();
        chk("pre_reset_busy", {stall, done}, 2'b10);
        start = 1'b1;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {stall, done, result, rd_out}, '0);
        mid();
        cyc();
        rst = 1'b0; start = 1'b0;
        mid();
        chk("post_reset_idle", {stall, done, result, rd_out}, '0);
        do_op(3'd0, 32'd6, 32'd7, 5'd18, 32'd42, 0, 0);

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom);
            ra = pick();
            rb = pick();
            rr = 5'($urandom);
            do_op(rf, ra, rb, rr, model(rf, ra, rb),
                  1'($urandom), 1'($urandom));
        end

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit sitting beside the ALU in the EX stage. It accepts one M-extension instruction from ID/EX with already-forwarded operands. It stalls the front of the pipeline while it iterates one bit per cycle, then presents a one-cycle result that the EX-stage result mux selects into EX/MEM. Operand width is parametrised; special divide cases complete early; a flush from a taken branch/jump in front of it kills the operation.

## Interface
Clock and reset: one clock; reset is asynchronous and active-high.

Parameters:
- `DATA_WIDTH`, 32, operand/result width; must be even, ≥ 8.
- `REGISTER_ADDR_WIDTH`, 5, destination register index width.

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous active-high reset.
- `start_EX`  in  1  ID/EX holds a valid M instruction (opcode 0110011, funct7 0000001).
- `flush_EX`  in  1  kill the instruction in EX; overrides `start_EX`.
- `funct3_EX`  in  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_val_EX`  in  DATA_WIDTH  forwarded rs1 value.
- `rs2_val_EX`  in  DATA_WIDTH  forwarded rs2 value.
- `rd_EX`  in  REGISTER_ADDR_WIDTH  destination register.
- `stall_muldiv`  out  1  hold PC, IF/ID and ID/EX; insert a bubble into EX/MEM.
- `done_muldiv`  out  1  result valid this cycle; lasts one cycle.
- `result_muldiv`  out  DATA_WIDTH  result; zero when `done_muldiv`=0.
- `rd_muldiv`  out  REGISTER_ADDR_WIDTH  latched rd; valid with `done_muldiv`.

## Operation
- States: IDLE, MUL, DIV, DONE.
- **IDLE**
  - `start_EX`=1 and `flush_EX`=0: latch operands, funct3 and rd.
    - Go to MUL for funct3[2]=0, otherwise DIV.
    - Divide by zero, or signed overflow (DIV/REM with rs1 = most-negative and rs2 = −1): precompute the result and go straight to DONE.
  - `stall_muldiv` = `start_EX & ~flush_EX`. This is combinational, so it stalls in the start cycle.
- **Sign handling**
  - Signed operands are converted to magnitudes. MULH treats both operands as signed; MULHSU treats rs1 only; DIV/REM treat both.
  - Product sign = sign1 ^ sign2.
  - Quotient sign = sign1 ^ sign2.
  - Remainder sign = sign of dividend.
  - Negation is two's complement, applied once when entering DONE.
- **MUL**
  - Shift-add over a 2·DATA_WIDTH accumulator, one multiplier bit per cycle.
  - Iteration counter runs 0..DATA_WIDTH−1.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- **DIV**
  - Restoring division, one quotient bit per cycle, DATA_WIDTH iterations.
  - The remainder register is DATA_WIDTH+1 bits.
- **Special divide results**
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Overflow: quotient = most-negative; remainder = 0.
- **MUL/DIV, last iteration:** go to DONE. `stall_muldiv`=1 in every MUL/DIV cycle.
- **DONE**
  - `done_muldiv`=1, `stall_muldiv`=0, result registered. The pipeline advances at this edge.
  - Always returns to IDLE. `start_EX` is ignored in DONE because it belongs to the same instruction.
- **Flush**
  - `flush_EX`=1 in any state: next state is IDLE with no `done_muldiv`.
  - `stall_muldiv`=0 in the flush cycle.
- **Reset:** state IDLE, counter 0, all datapath registers 0. All outputs are 0 during and after reset.

## Timing
- Start in cycle 0. Normal ops: DONE in cycle DATA_WIDTH+1, so stall covers cycles 0..DATA_WIDTH (33 cycles at W=32). Special divide cases: DONE in cycle 1.
- Back-to-back: the next M instruction can start in the cycle after DONE.
- Reset asserted mid-operation: outputs go to 0 immediately (asynchronously). No `done_muldiv` is produced for the aborted op.
- Operand inputs are don't-care after the start edge.

## Structure
- Package `muldiv_pkg`:
  - funct3 localparams: FUNCT3_MUL … FUNCT3_REMU.
  - State encoding (2 bits).
  - Helper function `twos_neg`.
- One natural sub-module, `muldiv_sign_fix`: combinational magnitude in/out and sign restore, instantiated at operand capture and at result. The FSM, counter and shift datapath stay in `ex_muldiv`.

## Test plan
- MUL 7 × 0xFFFFFFFD: `stall_muldiv` high for cycles 0..32; `done_muldiv` in cycle 33 with result 0xFFFFFFEB, `rd_muldiv` = `rd_EX`.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF with done in cycle 1; REMU 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same → 0.
- Flush at cycle 10 of a DIV: `stall_muldiv` low in cycle 10, state IDLE in 11, no `done_muldiv`. A new MUL started in cycle 11 completes in cycle 44.
- `rst` pulsed at cycle 5 of a MUL: outputs 0 immediately. After release, `start_EX` is accepted and the op completes normally.
- `start_EX` held high through DONE: exactly one `done_muldiv` per instruction.
